// File: rtl/muu_value_store.sv
// muu_value_store: on-chip value memory terminating the value-store
// write-command, write-beat and read-command channels. It streams read data
// out through a 2-entry output FIFO.
module muu_value_store #(
   parameter int MEMORY_WIDTH = 512,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [39:0]             wrcmd_data,
   input  logic                    wrcmd_valid,
   output logic                    wrcmd_ready,
   input  logic [MEMORY_WIDTH-1:0] wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [39:0]             rdcmd_data,
   input  logic                    rdcmd_valid,
   output logic                    rdcmd_ready,
   output logic [MEMORY_WIDTH-1:0] rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [7:0]              remain;
   logic [MEMORY_WIDTH-1:0] mem [DEPTH];
   logic [MEMORY_WIDTH-1:0] fifo [2];
   logic                    wptr, rptr;
   logic [1:0]              fifo_cnt;

   logic wrcmd_fire, rdcmd_fire, wr_fire, rd_pop, issue;

   // Beat-address bits above ADDR_WIDTH are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wrcmd_data[31:ADDR_WIDTH], rdcmd_data[31:ADDR_WIDTH]};

   assign rd_data = fifo[rptr];

   // Next-state, handshake and read-issue decode; readies depend only on state, wrcmd_valid and rst.
   always_comb begin
      state_nxt   = state;
      wrcmd_ready = 1'b0;
      rdcmd_ready = 1'b0;
      wr_ready    = 1'b0;
      wrcmd_fire  = 1'b0;
      rdcmd_fire  = 1'b0;
      wr_fire     = 1'b0;
      issue       = 1'b0;
      rd_valid    = (fifo_cnt != 2'd0);
      rd_pop      = (fifo_cnt != 2'd0) && rd_ready;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               wrcmd_ready = 1'b1;
               rdcmd_ready = !wrcmd_valid;
               wrcmd_fire  = wrcmd_valid;
               rdcmd_fire  = rdcmd_valid && !wrcmd_valid;
               if (wrcmd_fire && wrcmd_data[39:32] != 8'd0)
                  state_nxt = ST_WRITE;
               else if (rdcmd_fire && rdcmd_data[39:32] != 8'd0)
                  state_nxt = ST_READ;
            end
            ST_WRITE: begin
               wr_ready = 1'b1;
               wr_fire  = wr_valid;
               if (wr_fire && remain == 8'd1)
                  state_nxt = ST_IDLE;
            end
            ST_READ: begin
               // A pop from a full FIFO frees the slot in the same cycle.
               issue = (fifo_cnt < 2'd2) || rd_pop;
               if (issue && remain == 8'd1)
                  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Burst address and remaining-beat counter: load on command, step per beat.
   always_ff @(posedge clk) begin
      if (wrcmd_fire) begin
         addr   <= wrcmd_data[ADDR_WIDTH-1:0];
         remain <= wrcmd_data[39:32];
      end else if (rdcmd_fire) begin
         addr   <= rdcmd_data[ADDR_WIDTH-1:0];
         remain <= rdcmd_data[39:32];
      end else if (wr_fire || issue) begin
         addr   <= addr + 1'b1;
         remain <= remain - 1'b1;
      end
   end

   // Single-port RAM; the registered read lands directly in the FIFO slot, so no read is ever left in flight.
   always_ff @(posedge clk) begin
      if (wr_fire)
         mem[addr] <= wr_data;
      if (issue)
         fifo[wptr] <= mem[addr];
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= 1'b0;
         rptr     <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (issue)  wptr <= ~wptr;
         if (rd_pop) rptr <= ~rptr;
         if (issue && !rd_pop)
            fifo_cnt <= fifo_cnt + 2'd1;
         else if (!issue && rd_pop)
            fifo_cnt <= fifo_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_muu_value_store.sv
// tb_muu_value_store: directed bench for muu_value_store with hand-computed
// beat patterns and cycle-exact handshake expectations.
module tb_muu_value_store;

   logic         clk;
   logic         rst;
   logic [39:0]  wrcmd_data;
   logic         wrcmd_valid;
   logic         wrcmd_ready;
   logic [511:0] wr_data;
   logic         wr_valid;
   logic         wr_ready;
   logic [39:0]  rdcmd_data;
   logic         rdcmd_valid;
   logic         rdcmd_ready;
   logic [511:0] rd_data;
   logic         rd_valid;
   logic         rd_ready;

   int checks = 0;
   int errors = 0;

   muu_value_store #(.MEMORY_WIDTH(512), .ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .wrcmd_data(wrcmd_data), .wrcmd_valid(wrcmd_valid), .wrcmd_ready(wrcmd_ready),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rdcmd_data(rdcmd_data), .rdcmd_valid(rdcmd_valid), .rdcmd_ready(rdcmd_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Distinct beat pattern per index.
   function automatic logic [511:0] mk(input int unsigned k);
      mk = {16{32'hC0DE_0000 + k}};
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_burst(input logic [31:0] a, input int n, input int base);
      wrcmd_data  = {8'(n), a};
      wrcmd_valid = 1'b1;
      wr_valid    = 1'b1;
      wr_data     = mk(base);
      #1 check("wr_held", wr_ready, 1'b0);
      tick;
      wrcmd_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         wr_data  = mk(base + i);
         wr_valid = 1'b1;
         #1 check("wr_ready", wr_ready, 1'b1);
         tick;
      end
      wr_valid = 1'b0;
      #1 check("wr_done_idle", wrcmd_ready, 1'b1);
   endtask

   task automatic read_burst(input logic [31:0] a, input int n, input int base);
      rdcmd_data  = {8'(n), a};
      rdcmd_valid = 1'b1;
      rd_ready    = 1'b1;
      #1 check("rdcmd_ready", rdcmd_ready, 1'b1);
      tick;
      rdcmd_valid = 1'b0;
      #1 check("rd_latency", rd_valid, 1'b0);
      tick;
      for (int i = 0; i < n; i++) begin
         check("rd_valid", rd_valid, 1'b1);
         check("rd_data", rd_data, mk(base + i));
         if (i == n - 1) check("rd_cmd_free", wrcmd_ready, 1'b1);
         tick;
      end
      check("rd_end", rd_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      wrcmd_data = '0; wrcmd_valid = 1'b0;
      wr_data = '0;    wr_valid = 1'b0;
      rdcmd_data = '0; rdcmd_valid = 1'b0;
      rd_ready = 1'b0;
      repeat (2) tick;
      check("rst_wrcmd_ready", wrcmd_ready, 1'b0);
      check("rst_rdcmd_ready", rdcmd_ready, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      rst = 1'b0;
      #1;
      check("idle_wrcmd_ready", wrcmd_ready, 1'b1);
      check("idle_rdcmd_ready", rdcmd_ready, 1'b1);
      check("idle_wr_ready", wr_ready, 1'b0);
      tick;

      // Write then read back.
      write_burst(32'h10, 3, 100);
      tick;
      read_burst(32'h10, 3, 100);

      // Simultaneous commands: write wins, read sees its data.
      wrcmd_data = {8'd1, 32'd5}; wrcmd_valid = 1'b1;
      rdcmd_data = {8'd1, 32'd5}; rdcmd_valid = 1'b1;
      rd_ready = 1'b1;
      #1 check("sim_rdcmd_blocked", rdcmd_ready, 1'b0);
      check("sim_wrcmd_ready", wrcmd_ready, 1'b1);
      tick;
      wrcmd_valid = 1'b0;
      wr_valid = 1'b1; wr_data = mk(200);
      #1 check("sim_rdcmd_in_write", rdcmd_ready, 1'b0);
      check("sim_wr_ready", wr_ready, 1'b1);
      tick;
      wr_valid = 1'b0;
      #1 check("sim_rdcmd_ready", rdcmd_ready, 1'b1);
      tick;
      rdcmd_valid = 1'b0;
      #1 check("sim_rd_latency", rd_valid, 1'b0);
      tick;
      check("sim_rd_valid", rd_valid, 1'b1);
      check("sim_rd_data", rd_data, mk(200));
      tick;
      check("sim_rd_end", rd_valid, 1'b0);

      // Address wrap, upper address bits ignored.
      write_burst(32'hABCD_13FF, 2, 300);
      tick;
      read_burst(32'h3FF, 1, 300);
      read_burst(32'h000, 1, 301);

      // Backpressure with rd_ready pattern 1-0-0-1.
      write_burst(32'h100, 8, 400);
      rdcmd_data = {8'd8, 32'h100}; rdcmd_valid = 1'b1; rd_ready = 1'b1;
      tick;
      rdcmd_valid = 1'b0;
      begin
         int idx = 0;
         for (int c = 0; c < 40 && idx < 8; c++) begin
            rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (rd_valid) begin
               check("bp_data", rd_data, mk(400 + idx));
               if (rd_ready) idx++;
            end
            tick;
         end
         check("bp_count", idx, 8);
         check("bp_drained", rd_valid, 1'b0);
      end

      // Zero-length commands.
      rd_ready = 1'b1;
      wrcmd_data = {8'd0, 32'h20}; wrcmd_valid = 1'b1;
      tick;
      wrcmd_valid = 1'b0;
      #1 check("zw_no_wr_ready", wr_ready, 1'b0);
      check("zw_idle", wrcmd_ready, 1'b1);
      rdcmd_data = {8'd0, 32'h20}; rdcmd_valid = 1'b1;
      tick;
      rdcmd_valid = 1'b0;
      #1 check("zr_no_rd_valid", rd_valid, 1'b0);
      check("zr_idle", rdcmd_ready, 1'b1);
      tick;
      check("zr_no_rd_valid2", rd_valid, 1'b0);

      // Reset in the middle of a stalled read.
      write_burst(32'h200, 6, 500);
      rd_ready = 1'b0;
      rdcmd_data = {8'd6, 32'h200}; rdcmd_valid = 1'b1;
      tick;
      rdcmd_valid = 1'b0;
      repeat (3) tick;
      check("mr_valid_stalled", rd_valid, 1'b1);
      check("mr_head", rd_data, mk(500));
      rst = 1'b1;
      #1 check("mr_rst_wrcmd_ready", wrcmd_ready, 1'b0);
      check("mr_rst_rdcmd_ready", rdcmd_ready, 1'b0);
      check("mr_rst_wr_ready", wr_ready, 1'b0);
      tick;
      rst = 1'b0;
      #1 check("mr_flushed", rd_valid, 1'b0);
      check("mr_idle", wrcmd_ready, 1'b1);
      read_burst(32'h202, 1, 502);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
